tt_stim_player: RTL and testbench

TT_STIM_PLAYER -- requirements
Module: tt_stim_player

---
 rtl/tt_stim_pkg.sv | 12 +
 rtl/tt_stim_player_fifo.sv | 33 +++
 rtl/tt_stim_player.sv | 88 ++++++++
 tb/tb_tt_stim_player.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/tt_stim_pkg.sv
// tt_stim_pkg: shared FSM states, vector field offsets and helpers for the stimulus player
package tt_stim_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, FINISH} state_t;
  localparam int VEC_W = 24;
  localparam int UI_LSB = 16;
  localparam int UIO_LSB = 8;
  localparam int EXP_LSB = 0;
  localparam logic [3:0] NONE_IDX = 4'hF;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/tt_stim_player_fifo.sv
// stim_fifo: single-clock vector FIFO with extra-bit pointers for full/empty
module stim_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rd_data = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en && !full) wp <= wp + 1'b1;
      if (rd_en && !empty) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wp[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/tt_stim_player.sv
// tt_stim_player: plays queued stimulus vectors into a DUT and checks its response
module tt_stim_player
  import tt_stim_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [VEC_W-1:0]  wr_data,
  output logic              wr_ready,
  input  logic              start,
  output logic [7:0]        ui_drv,
  output logic [7:0]        uio_drv,
  input  logic [7:0]        uo_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [3:0]        first_fail
);
  state_t state;
  logic [VEC_W-1:0] head;
  logic full, empty;
  logic [7:0] exp_q;
  logic [3:0] idx, cnt;
  assign wr_ready = (state == IDLE) && !full;
  assign busy = state != IDLE;
  stim_fifo #(.DEPTH(DEPTH), .WIDTH(VEC_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_valid && wr_ready),
    .wr_data(wr_data),
    .rd_en(state == DRIVE),
    .rd_data(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ui_drv <= '0;
      uio_drv <= '0;
      exp_q <= '0;
      idx <= '0;
      cnt <= '0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_fail <= NONE_IDX;
    end else begin
      done <= state == FINISH;
      case (state)
        IDLE: if (start) begin
          err_count <= '0;
          first_fail <= NONE_IDX;
          idx <= '0;
          state <= empty ? FINISH : DRIVE;
        end
        DRIVE: begin
          ui_drv <= head[UI_LSB +: 8];
          uio_drv <= head[UIO_LSB +: 8];
          exp_q <= head[EXP_LSB +: 8];
          cnt <= 4'(SETTLE - 1);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= CHECK;
        end
        CHECK: begin
          if (uo_in != exp_q) begin
            err_count <= sat_inc(err_count);
            if (first_fail == NONE_IDX) first_fail <= idx;
          end
          idx <= idx + 1'b1;
          state <= empty ? FINISH : DRIVE;
        end
        FINISH: begin
          pass <= err_count == '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_stim_player.sv
// tb_tt_stim_player: scoreboard bench for the stimulus player with a loopback uo=ui*2 DUT
module tb_tt_stim_player;
  localparam int DEPTH = 8;
  localparam int SETTLE = 2;
  logic clk = 1'b0, rst = 1'b1, wr_valid = 1'b0, start = 1'b0;
  logic [23:0] wr_data = '0;
  logic [7:0] ui_drv, uio_drv, uo_in, err_count;
  logic wr_ready, busy, done, pass;
  logic [3:0] first_fail;
  int errors = 0, checks = 0, cyc = 0, done_cnt = 0, n_play = 0, start_cyc = 0;
  typedef struct {logic p; logic [7:0] e; logic [3:0] f; int lat;} exp_t;
  exp_t sb[$];
  exp_t me;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign uo_in = {ui_drv[6:0], 1'b0};
  tt_stim_player #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .ui_drv(ui_drv), .uio_drv(uio_drv), .uo_in(uo_in), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .first_fail(first_fail)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) chk("unexpected done", 1, 0);
      else begin
        me = sb.pop_front();
        chk("pass", int'(pass), int'(me.p));
        chk("err_count", int'(err_count), int'(me.e));
        chk("first_fail", int'(first_fail), int'(me.f));
        chk("done latency", cyc - start_cyc, me.lat);
      end
      done_cnt++;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [23:0] v, output logic acc);
    wr_valid = 1'b1;
    wr_data = v;
    acc = wr_ready;
    tick();
    wr_valid = 1'b0;
  endtask
  task automatic play(input int n, input logic p, input logic [7:0] e, input logic [3:0] f);
    sb.push_back('{p, e, f, n * (SETTLE + 2) + 2});
    n_play++;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done;
    for (int i = 0; i < 400 && done_cnt < n_play; i++) tick();
    chk("done seen", done_cnt, n_play);
    tick();
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, " ui_drv"}, int'(ui_drv), 0);
    chk({tag, " uio_drv"}, int'(uio_drv), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " pass"}, int'(pass), 0);
    chk({tag, " err_count"}, int'(err_count), 0);
    chk({tag, " first_fail"}, int'(first_fail), 15);
    chk({tag, " wr_ready"}, int'(wr_ready), 1);
  endtask
  initial begin
    logic a;
    int n;
    tick();
    tick();
    chk_rst("reset");
    rst = 1'b0;
    tick();
    wr({8'h01, 8'h00, 8'h02}, a);
    wr({8'h02, 8'h00, 8'h04}, a);
    wr({8'h03, 8'h00, 8'h06}, a);
    play(3, 1'b1, 8'd0, 4'hF);
    wait_done();
    chk("hold ui_drv", int'(ui_drv), 3);
    chk("idle busy", int'(busy), 0);
    wr({8'h01, 8'h00, 8'h02}, a);
    wr({8'h02, 8'h00, 8'h05}, a);
    wr({8'h03, 8'hA5, 8'h06}, a);
    play(3, 1'b0, 8'd1, 4'd1);
    wait_done();
    chk("hold uio_drv", int'(uio_drv), 8'hA5);
    n = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr({8'(i + 1), 8'h00, (i == 5 || i == 6 || i == DEPTH) ? 8'hEE : 8'(2 * (i + 1))}, a);
      n += int'(a);
      if (i == DEPTH - 1) chk("wr_ready when full", int'(wr_ready), 0);
    end
    chk("accepted writes", n, DEPTH);
    play(DEPTH, 1'b0, 8'd2, 4'd5);
    wait_done();
    play(0, 1'b1, 8'd0, 4'hF);
    wait_done();
    wr({8'h01, 8'h00, 8'h02}, a);
    wr({8'h02, 8'h00, 8'h04}, a);
    play(2, 1'b1, 8'd0, 4'hF);
    tick();
    tick();
    chk("busy mid play", int'(busy), 1);
    chk("wr_ready busy", int'(wr_ready), 0);
    start = 1'b1;
    wr({8'h07, 8'h00, 8'h00}, a);
    start = 1'b0;
    chk("err_count after stray", int'(err_count), 0);
    wait_done();
    play(0, 1'b1, 8'd0, 4'hF);
    wait_done();
    wr({8'h01, 8'h00, 8'h02}, a);
    wr({8'h02, 8'h00, 8'h04}, a);
    wr({8'h03, 8'h00, 8'h06}, a);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("busy before abort", int'(busy), 1);
    chk("ui_drv before abort", int'(ui_drv), 2);
    rst = 1'b1;
    #1;
    chk_rst("abort");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    play(0, 1'b1, 8'd0, 4'hF);
    wait_done();
    chk("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
